// File: rtl/spi_flash_responder.sv
// SPI NOR flash responder (mode 0) oversampled on okClk: ID, status, WREN/WRDI,
// read and page program against an external byte-wide backing store.
module spi_flash_responder #(
  parameter logic [23:0] JEDEC_ID    = 24'h20BA18,
  parameter int unsigned PROG_CYCLES = 1024
) (
  input  logic        okClk_i,
  input  logic        reset_i,
  input  logic        flash_c_i,
  input  logic        flash_s_n_i,
  input  logic        flash_d_i,
  output logic        flash_q_o,
  output logic [23:0] mem_addr_o,
  output logic        mem_re_o,
  input  logic [7:0]  mem_rdata_i,
  output logic        mem_we_o,
  output logic [7:0]  mem_wdata_o,
  output logic        wel_o,
  output logic        wip_o
);

  localparam int BW = $clog2(PROG_CYCLES + 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DOUT   = 3'd3;
  localparam logic [2:0] S_DIN    = 3'd4;
  localparam logic [2:0] S_IGNORE = 3'd5;

  localparam logic [1:0] K_STAT  = 2'd0;
  localparam logic [1:0] K_JEDEC = 2'd1;
  localparam logic [1:0] K_READ  = 2'd2;
  localparam logic [1:0] K_WRITE = 2'd3;

  function automatic logic [7:0] jedec_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    jedec_byte = JEDEC_ID[23:16];
      2'd1:    jedec_byte = JEDEC_ID[15:8];
      2'd2:    jedec_byte = JEDEC_ID[7:0];
      default: jedec_byte = 8'h00;
    endcase
  endfunction

  logic [1:0]    c_sync_q, s_sync_q, d_sync_q;
  logic          c_prev_q, s_prev_q, re_dly_q;
  logic [2:0]    state_q, state_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    rx_q, rx_d, tx_q, tx_d, wdata_q, wdata_d;
  logic [23:0]   addr_q, addr_d;
  logic [1:0]    kind_q, kind_d, jidx_q, jidx_d;
  logic          q_q, q_d, wel_q, wel_d, wip_q, wip_d, wrote_q, wrote_d;
  logic          re_q, re_d, we_q, we_d;
  logic [BW-1:0] busy_q, busy_d;
  logic          c_rise, c_fall, cs_high, cs_fall, sbit;
  logic [7:0]    opcode, tx_cur;
  logic [1:0]    jidx_next;

  assign c_rise  = c_sync_q[1] & ~c_prev_q;
  assign c_fall  = ~c_sync_q[1] & c_prev_q;
  assign cs_high = s_sync_q[1];
  assign cs_fall = ~s_sync_q[1] & s_prev_q;
  assign sbit    = d_sync_q[1];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    addr_d    = addr_q;
    kind_d    = kind_q;
    jidx_d    = jidx_q;
    q_d       = q_q;
    wel_d     = wel_q;
    wip_d     = wip_q;
    busy_d    = busy_q;
    wrote_d   = wrote_q;
    wdata_d   = wdata_q;
    re_d      = 1'b0;
    we_d      = 1'b0;
    opcode    = {rx_q[6:0], sbit};
    jidx_next = (jidx_q == 2'd3) ? 2'd3 : jidx_q + 2'd1;
    // read data arrives the cycle after the strobe and may meet a falling edge
    tx_cur    = re_dly_q ? mem_rdata_i : tx_q;
    tx_d      = tx_cur;

    if (wip_q) begin
      if (busy_q == {BW{1'b0}}) begin
        wip_d = 1'b0;
      end else begin
        busy_d = busy_q - BW'(1);
      end
    end else begin
      busy_d = busy_q;
    end

    if (we_q) begin
      addr_d[7:0] = addr_q[7:0] + 8'd1;
    end else begin
      addr_d = addr_q;
    end

    if (cs_high) begin
      if ((state_q == S_DIN) && wrote_q) begin
        wel_d  = 1'b0;
        wip_d  = 1'b1;
        busy_d = BW'(PROG_CYCLES);
      end else begin
        wel_d = wel_q;
      end
      state_d   = S_IDLE;
      bit_cnt_d = 5'd0;
      rx_d      = 8'h00;
      q_d       = 1'b0;
      wrote_d   = 1'b0;
    end else if (cs_fall) begin
      state_d   = S_CMD;
      bit_cnt_d = 5'd0;
      q_d       = 1'b0;
    end else begin
      case (state_q)
        S_CMD: begin
          if (c_rise) begin
            rx_d      = opcode;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              state_d   = S_IGNORE;
              if (wip_q && (opcode != 8'h05)) begin
                state_d = S_IGNORE;
              end else begin
                case (opcode)
                  8'h06: wel_d = 1'b1;
                  8'h04: wel_d = 1'b0;
                  8'h05: begin
                    kind_d  = K_STAT;
                    tx_d    = {6'b000000, wel_q, wip_q};
                    state_d = S_DOUT;
                  end
                  8'h9F: begin
                    kind_d  = K_JEDEC;
                    jidx_d  = 2'd0;
                    tx_d    = jedec_byte(2'd0);
                    state_d = S_DOUT;
                  end
                  8'h03: begin
                    kind_d  = K_READ;
                    state_d = S_ADDR;
                  end
                  8'h02: begin
                    kind_d  = K_WRITE;
                    state_d = wel_q ? S_ADDR : S_IGNORE;
                  end
                  default: state_d = S_IGNORE;
                endcase
              end
            end else begin
              state_d = S_CMD;
            end
          end else begin
            state_d = S_CMD;
          end
        end
        S_ADDR: begin
          if (c_rise) begin
            addr_d    = {addr_q[22:0], sbit};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = 5'd0;
              re_d      = (kind_q == K_READ);
              state_d   = (kind_q == K_READ) ? S_DOUT : S_DIN;
            end else begin
              state_d = S_ADDR;
            end
          end else begin
            state_d = S_ADDR;
          end
        end
        S_DOUT: begin
          if (c_fall) begin
            q_d  = tx_cur[7];
            tx_d = {tx_cur[6:0], 1'b0};
          end else if (c_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              case (kind_q)
                K_STAT:  tx_d = {6'b000000, wel_q, wip_q};
                K_JEDEC: begin
                  jidx_d = jidx_next;
                  tx_d   = jedec_byte(jidx_next);
                end
                K_READ: begin
                  addr_d = addr_q + 24'd1;
                  re_d   = 1'b1;
                end
                default: tx_d = 8'h00;
              endcase
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end else begin
            q_d = q_q;
          end
        end
        S_DIN: begin
          if (c_rise) begin
            rx_d      = opcode;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              we_d      = 1'b1;
              wdata_d   = opcode;
              wrote_d   = 1'b1;
            end else begin
              we_d = 1'b0;
            end
          end else begin
            rx_d = rx_q;
          end
        end
        S_IGNORE: q_d = 1'b0;
        S_IDLE:   q_d = 1'b0;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // chip-select sync resets low so a select held across reset never looks like a new frame
  always_ff @(posedge okClk_i or posedge reset_i) begin
    if (reset_i) begin
      c_sync_q  <= 2'b00;
      s_sync_q  <= 2'b00;
      d_sync_q  <= 2'b00;
      c_prev_q  <= 1'b0;
      s_prev_q  <= 1'b0;
      re_dly_q  <= 1'b0;
      state_q   <= S_IDLE;
      bit_cnt_q <= 5'd0;
      rx_q      <= 8'h00;
      tx_q      <= 8'h00;
      wdata_q   <= 8'h00;
      addr_q    <= 24'h000000;
      kind_q    <= K_STAT;
      jidx_q    <= 2'd0;
      q_q       <= 1'b0;
      wel_q     <= 1'b0;
      wip_q     <= 1'b0;
      busy_q    <= {BW{1'b0}};
      wrote_q   <= 1'b0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      c_sync_q  <= {c_sync_q[0], flash_c_i};
      s_sync_q  <= {s_sync_q[0], flash_s_n_i};
      d_sync_q  <= {d_sync_q[0], flash_d_i};
      c_prev_q  <= c_sync_q[1];
      s_prev_q  <= s_sync_q[1];
      re_dly_q  <= re_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      kind_q    <= kind_d;
      jidx_q    <= jidx_d;
      q_q       <= q_d;
      wel_q     <= wel_d;
      wip_q     <= wip_d;
      busy_q    <= busy_d;
      wrote_q   <= wrote_d;
      re_q      <= re_d;
      we_q      <= we_d;
    end
  end

  assign flash_q_o   = q_q;
  assign mem_addr_o  = addr_q;
  assign mem_re_o    = re_q;
  assign mem_we_o    = we_q;
  assign mem_wdata_o = wdata_q;
  assign wel_o       = wel_q;
  assign wip_o       = wip_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI master tasks, byte-store model, logs.
module tb_spi_flash_responder;

  localparam int HALF = 6;

  logic        clk, rst, fc, fs_n, fd, fq;
  logic [23:0] maddr;
  logic        mre, mwe, wel, wip;
  logic [7:0]  mrdata, mwdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_viol   = 0;
  logic [7:0]  mem [int];
  logic [23:0] re_log [$];
  logic [23:0] we_addr [$];
  logic [7:0]  we_data [$];
  logic [7:0]  rb;

  spi_flash_responder dut (
    .okClk_i     (clk),
    .reset_i     (rst),
    .flash_c_i   (fc),
    .flash_s_n_i (fs_n),
    .flash_d_i   (fd),
    .flash_q_o   (fq),
    .mem_addr_o  (maddr),
    .mem_re_o    (mre),
    .mem_rdata_i (mrdata),
    .mem_we_o    (mwe),
    .mem_wdata_o (mwdata),
    .wel_o       (wel),
    .wip_o       (wip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // backing store, strobe logs and strobe-rule monitor
  always @(posedge clk) begin
    if (mre) begin
      mrdata <= mem.exists(int'(maddr)) ? mem[int'(maddr)] : 8'hEE;
      re_log.push_back(maddr);
    end
    if (mwe) begin
      mem[int'(maddr)] = mwdata;
      we_addr.push_back(maddr);
      we_data.push_back(mwdata);
    end
    if ((mre && mwe) || ((mre || mwe) && fs_n)) n_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      fd = tx[i];
      wait_cyc(HALF);
      fc = 1'b1;
      rx[i] = fq;
      wait_cyc(HALF);
      fc = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    xfer_bits(tx, 8, rx);
  endtask

  task automatic sel;
    fs_n = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic desel;
    wait_cyc(HALF);
    fs_n = 1'b1;
    fd   = 1'b0;
    wait_cyc(4 * HALF);
  endtask

  task automatic one_byte_cmd(input logic [7:0] op);
    logic [7:0] r;
    sel();
    xfer(op, r);
    desel();
  endtask

  task automatic read_status(output logic [7:0] st);
    logic [7:0] r;
    sel();
    xfer(8'h05, r);
    xfer(8'h00, st);
    desel();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] exp_b [4];
    rst = 1'b1; fs_n = 1'b1; fc = 1'b0; fd = 1'b0;
    wait_cyc(5);
    check("rst_q", fq, 1'b0);
    check("rst_re_we", {mre, mwe}, 2'b00);
    check("rst_addr", maddr, 24'h0);
    check("rst_wel_wip", {wel, wip}, 2'b00);
    rst = 1'b0;
    wait_cyc(10);

    // JEDEC ID then zero fill
    exp_b[0] = 8'h20; exp_b[1] = 8'hBA; exp_b[2] = 8'h18; exp_b[3] = 8'h00;
    sel();
    xfer(8'h9F, r);
    for (int i = 0; i < 4; i++) begin
      xfer(8'h00, r);
      check($sformatf("jedec_b%0d", i), r, exp_b[i]);
    end
    desel();

    // sequential read
    mem[32'h10] = 8'hA5; mem[32'h11] = 8'h5A; mem[32'h12] = 8'h3C;
    exp_b[0] = 8'hA5; exp_b[1] = 8'h5A; exp_b[2] = 8'h3C;
    re_log.delete();
    sel();
    xfer(8'h03, r); xfer(8'h00, r); xfer(8'h00, r); xfer(8'h10, r);
    for (int i = 0; i < 3; i++) begin
      xfer(8'h00, r);
      check($sformatf("rd_b%0d", i), r, exp_b[i]);
    end
    desel();
    check("rd_re_cnt_ge3", 32'(re_log.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (re_log.size() > i) check($sformatf("rd_re_addr%0d", i), re_log[i], 24'h10 + 24'(i));
    end

    // read wraps at top of address space
    mem[32'hFFFFFF] = 8'h77; mem[32'h0] = 8'h88;
    re_log.delete();
    sel();
    xfer(8'h03, r); xfer(8'hFF, r); xfer(8'hFF, r); xfer(8'hFF, r);
    xfer(8'h00, r); check("wrap_b0", r, 8'h77);
    xfer(8'h00, r); check("wrap_b1", r, 8'h88);
    desel();
    check("wrap_re_cnt_ge2", 32'(re_log.size() >= 2), 32'd1);
    if (re_log.size() >= 2) begin
      check("wrap_addr0", re_log[0], 24'hFFFFFF);
      check("wrap_addr1", re_log[1], 24'h000000);
    end

    // page program without write enable is ignored
    we_addr.delete(); we_data.delete();
    sel();
    xfer(8'h02, r); xfer(8'h00, r); xfer(8'h01, r); xfer(8'hFE, r); xfer(8'h11, r);
    desel();
    check("pp_nowel_we", we_addr.size(), 32'd0);
    check("pp_nowel_wip", wip, 1'b0);

    // page program with wrap inside the page
    one_byte_cmd(8'h06);
    sel();
    xfer(8'h02, r); xfer(8'h00, r); xfer(8'h01, r); xfer(8'hFE, r);
    xfer(8'h11, r); xfer(8'h22, r); xfer(8'h33, r);
    desel();
    check("pp_we_cnt", we_addr.size(), 32'd3);
    if (we_addr.size() == 3) begin
      check("pp_a0", {we_addr[0], we_data[0]}, {24'h0001FE, 8'h11});
      check("pp_a1", {we_addr[1], we_data[1]}, {24'h0001FF, 8'h22});
      check("pp_a2", {we_addr[2], we_data[2]}, {24'h000100, 8'h33});
    end
    check("pp_wel_wip", {wel, wip}, 2'b01);
    read_status(r);
    check("pp_status_busy", r, 8'h01);
    one_byte_cmd(8'h06);
    read_status(r);
    check("busy_wren_ignored", r, 8'h01);
    wait_cyc(1100);
    read_status(r);
    check("pp_status_done", r, 8'h00);

    // write enable latch set/clear
    one_byte_cmd(8'h06);
    read_status(r);
    check("wren_status", r, 8'h02);
    one_byte_cmd(8'h04);
    read_status(r);
    check("wrdi_status", r, 8'h00);

    // reset during address phase of a program
    we_addr.delete(); we_data.delete();
    one_byte_cmd(8'h06);
    sel();
    xfer(8'h02, r); xfer(8'h00, r); xfer_bits(8'h10, 4, r);
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(3);
    check("rst_mid_q", fq, 1'b0);
    rst = 1'b0;
    wait_cyc(6);
    // select still low: this frame must not be decoded
    xfer(8'h9F, r);
    xfer(8'h00, r);
    check("rst_no_fresh_cs", r, 8'h00);
    desel();
    check("rst_mid_we", we_addr.size(), 32'd0);
    check("rst_mid_wel", wel, 1'b0);

    // deselect after a partial data byte
    one_byte_cmd(8'h06);
    sel();
    xfer(8'h02, r); xfer(8'h00, r); xfer(8'h02, r); xfer(8'h00, r);
    xfer_bits(8'hAB, 5, r);
    desel();
    check("part_we", we_addr.size(), 32'd0);
    check("part_q", fq, 1'b0);
    check("part_wel_wip", {wel, wip}, 2'b10);
    one_byte_cmd(8'h04);

    check("strobe_rules", n_viol, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
